// File: rtl/conv_out_packer_pkg.sv
// Shared types and width derivations for the conv output packer.
package conv_out_packer_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCalc  = 3'd1,
        StRun   = 3'd2,
        StFlush = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Cycles spent computing the beat total after Start.
    localparam int unsigned CALC_CYCLES = 2;

    // Width of one input beat.
    function automatic int unsigned calc_in_w(input int unsigned picture_num,
                                              input int unsigned channel_out_num,
                                              input int unsigned width_data);
        return picture_num * channel_out_num * width_data;
    endfunction

    // Width of one packed output word.
    function automatic int unsigned calc_out_w(input int unsigned in_w,
                                               input int unsigned pack_num);
        return in_w * pack_num;
    endfunction

    // Width of the beat/word counters: rows^2 * channel groups.
    function automatic int unsigned calc_cnt_w(input int unsigned width_feature_size,
                                               input int unsigned width_channel_num_reg);
        return 2 * width_feature_size + width_channel_num_reg;
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous FIFO with async reset; combinational read of the head entry.
module conv_out_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/conv_out_packer.sv
// Buffers quantised conv beats, packs PACK_NUM beats per word and frames a layer
// for the write DMA (M_Last on the final word, Done pulse once it is taken).
module conv_out_packer
    import conv_out_packer_pkg::*;
#(
    parameter int unsigned CHANNEL_OUT_NUM       = 8,
    parameter int unsigned PICTURE_NUM           = 1,
    parameter int unsigned WIDTH_DATA            = 8,
    parameter int unsigned PACK_NUM              = 2,
    parameter int unsigned FIFO_DEPTH            = 16,
    parameter int unsigned WIDTH_FEATURE_SIZE    = 12,
    parameter int unsigned WIDTH_CHANNEL_NUM_REG = 10,
    localparam int unsigned IN_W  = calc_in_w(PICTURE_NUM, CHANNEL_OUT_NUM, WIDTH_DATA),
    localparam int unsigned OUT_W = calc_out_w(IN_W, PACK_NUM),
    localparam int unsigned CNT_W = calc_cnt_w(WIDTH_FEATURE_SIZE, WIDTH_CHANNEL_NUM_REG)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    input  logic [IN_W-1:0]                  S_Data,
    input  logic                             S_Valid,
    output logic                             S_Ready,
    output logic [OUT_W-1:0]                 M_Data,
    output logic                             M_Valid,
    input  logic                             M_Ready,
    output logic                             M_Last,
    output logic                             Done,
    output logic                             Busy
);

    localparam int unsigned SQ_W = 2 * WIDTH_FEATURE_SIZE;
    localparam int unsigned PK_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

    state_e                           state_q, state_d;
    logic                             calc_cnt_q, calc_cnt_d;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_q, row_d;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_q, ch_d;
    logic [SQ_W-1:0]                  row_sq_q, row_sq_d;
    logic [CNT_W-1:0]                 tot_q, tot_d;
    logic [CNT_W-1:0]                 in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]                 pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]                 out_cnt_q, out_cnt_d;
    logic [PK_W-1:0]                  pk_idx_q, pk_idx_d;
    logic [OUT_W-1:0]                 pack_q, pack_d;
    logic [OUT_W-1:0]                 m_data_q, m_data_d;
    logic                             m_valid_q, m_valid_d;
    logic                             m_last_q, m_last_d;

    logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [IN_W-1:0]  fifo_dout;
    logic             frame_start, s_ready, out_free, m_xfer, last_beat, word_full;
    logic [OUT_W-1:0] word_v;

    conv_out_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .rd_en (fifo_rd),
        .din   (S_Data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake and pack-side control decodes.
    always_comb begin
        frame_start = (state_q == StIdle) && Start;
        // Stop accepting once the whole frame is in, so surplus beats stay upstream.
        s_ready     = (state_q == StRun) && !fifo_full && (in_cnt_q != tot_q);
        fifo_wr     = S_Valid && s_ready;
        out_free    = !m_valid_q || M_Ready;
        m_xfer      = m_valid_q && M_Ready;
        fifo_rd     = !fifo_empty && out_free && ((state_q == StRun) || (state_q == StFlush));
        last_beat   = (pop_cnt_q == (tot_q - CNT_W'(1)));
        word_full   = (pk_idx_q == PK_W'(PACK_NUM - 1));
    end

    // FSM next state plus the two-cycle registered TOT multiply.
    always_comb begin
        state_d    = state_q;
        calc_cnt_d = calc_cnt_q;
        row_d      = row_q;
        ch_d       = ch_q;
        row_sq_d   = row_sq_q;
        tot_d      = tot_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    row_d      = Row_Num_Out_REG;
                    ch_d       = Channel_Out_Num_REG;
                    calc_cnt_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                calc_cnt_d = 1'b1;
                if (!calc_cnt_q) begin
                    row_sq_d = SQ_W'(row_q) * SQ_W'(row_q);
                end else begin
                    tot_d   = CNT_W'(row_sq_q) * CNT_W'(ch_q);
                    state_d = (tot_d == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (in_cnt_q == tot_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (m_xfer && m_last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Counters, pack register and single output stage.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        pop_cnt_d = pop_cnt_q;
        out_cnt_d = out_cnt_q;
        pk_idx_d  = pk_idx_q;
        pack_d    = pack_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        word_v    = pack_q;
        word_v[pk_idx_q*IN_W +: IN_W] = fifo_dout;

        if (frame_start) begin
            in_cnt_d  = '0;
            pop_cnt_d = '0;
            out_cnt_d = '0;
            pk_idx_d  = '0;
            pack_d    = '0;
        end

        if (fifo_wr) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end

        if (m_xfer) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (fifo_rd) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
            if (word_full || last_beat) begin
                // pack_q is cleared after every load, so unused slots of a short word are zero.
                m_data_d  = word_v;
                m_valid_d = 1'b1;
                m_last_d  = last_beat;
                pack_d    = '0;
                pk_idx_d  = '0;
            end else begin
                pack_d   = word_v;
                pk_idx_d = pk_idx_q + PK_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            calc_cnt_q <= 1'b0;
            row_q      <= '0;
            ch_q       <= '0;
            row_sq_q   <= '0;
            tot_q      <= '0;
            in_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            out_cnt_q  <= '0;
            pk_idx_q   <= '0;
            pack_q     <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            calc_cnt_q <= calc_cnt_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            row_sq_q   <= row_sq_d;
            tot_q      <= tot_d;
            in_cnt_q   <= in_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            out_cnt_q  <= out_cnt_d;
            pk_idx_q   <= pk_idx_d;
            pack_q     <= pack_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
        end
    end

    assign S_Ready = s_ready;
    assign M_Data  = m_data_q;
    assign M_Valid = m_valid_q;
    assign M_Last  = m_last_q;
    assign Done    = (state_q == StDone);
    assign Busy    = (state_q != StIdle);

endmodule

// File: tb/tb_conv_out_packer.sv
// Scoreboard bench for conv_out_packer: randomized frames against a packing model.
module tb_conv_out_packer;

    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 128;
    localparam int unsigned P     = 2;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Start = 1'b0;
    logic [11:0]      Row_Num_Out_REG = '0;
    logic [9:0]       Channel_Out_Num_REG = '0;
    logic [IN_W-1:0]  S_Data = '0;
    logic             S_Valid = 1'b0;
    logic             S_Ready;
    logic [OUT_W-1:0] M_Data;
    logic             M_Valid;
    logic             M_Ready = 1'b0;
    logic             M_Last;
    logic             Done;
    logic             Busy;

    conv_out_packer #(
        .CHANNEL_OUT_NUM       (8),
        .PICTURE_NUM           (1),
        .WIDTH_DATA            (8),
        .PACK_NUM              (P),
        .FIFO_DEPTH            (DEPTH),
        .WIDTH_FEATURE_SIZE    (12),
        .WIDTH_CHANNEL_NUM_REG (10)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .Start               (Start),
        .Row_Num_Out_REG     (Row_Num_Out_REG),
        .Channel_Out_Num_REG (Channel_Out_Num_REG),
        .S_Data              (S_Data),
        .S_Valid             (S_Valid),
        .S_Ready             (S_Ready),
        .M_Data              (M_Data),
        .M_Valid             (M_Valid),
        .M_Ready             (M_Ready),
        .M_Last              (M_Last),
        .Done                (Done),
        .Busy                (Busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int words_seen = 0;
    int last_word_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int mr_mode = 0;

    logic [OUT_W-1:0] exp_data_q[$];
    logic             exp_last_q[$];

    logic             hold_pend = 1'b0;
    logic [OUT_W-1:0] hold_data = '0;
    logic             hold_last = 1'b0;
    logic             prev_done = 1'b0;

    task automatic chk(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout, required completion", name);
    endtask

    always @(posedge clk) cyc++;

    // M_Ready pattern generator.
    always @(posedge clk) begin
        #1;
        case (mr_mode)
            0: M_Ready = 1'b1;
            1: M_Ready = !M_Ready;
            2: M_Ready = 1'(($urandom & 32'h3) != 0);
            default: M_Ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pop, hold-stability, Done shape, accepted-beat count.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", OUT_W'(M_Valid), OUT_W'(1'b1));
                chk("hold_data", M_Data, hold_data);
                chk("hold_last", OUT_W'(M_Last), OUT_W'(hold_last));
            end
            if (M_Valid && M_Ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h, required no word", M_Data);
                end else begin
                    chk("word_data", M_Data, exp_data_q.pop_front());
                    chk("word_last", OUT_W'(M_Last), OUT_W'(exp_last_q.pop_front()));
                end
                words_seen++;
                last_word_cyc = cyc;
            end
            hold_pend = M_Valid && !M_Ready;
            hold_data = M_Data;
            hold_last = M_Last;
            if (S_Valid && S_Ready) acc_cnt++;
            if (prev_done) begin
                chk("done_width", OUT_W'(Done), OUT_W'(1'b0));
                chk("busy_after_done", OUT_W'(Busy), OUT_W'(1'b0));
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = Done;
        end
    end

    // One frame: build expected words, start, feed beats, then wait for Done.
    task automatic run_frame(input int row, input int ch, input int vmode, input int mmode,
                             input int extra, input int abort_at, input int release_after);
        int tot;
        int nw;
        int i;
        int guard;
        int d0;
        bit acc;
        logic [IN_W-1:0]  beats[$];
        logic [OUT_W-1:0] word;
        tot = row * row * ch;
        nw  = (tot + P - 1) / P;
        beats.delete();
        for (int b = 0; b < tot; b++) beats.push_back({$urandom, $urandom});
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < P; k++) begin
                if (w * P + k < tot) word[k*IN_W +: IN_W] = beats[w*P + k];
            end
            exp_data_q.push_back(word);
            exp_last_q.push_back(w == nw - 1);
        end
        mr_mode    = mmode;
        acc_cnt    = 0;
        words_seen = 0;
        d0         = done_cnt;
        Row_Num_Out_REG     = 12'(row);
        Channel_Out_Num_REG = 10'(ch);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;

        i = 0;
        guard = 0;
        while (i < tot) begin
            S_Valid = (vmode == 0) ? 1'b1 : 1'(($urandom & 32'h3) != 0);
            S_Data  = beats[i];
            @(negedge clk);
            acc = S_Valid && S_Ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
            if (mmode == 3 && guard == release_after) begin
                chk("fill_accepted", OUT_W'(acc_cnt), OUT_W'(DEPTH + P));
                chk("fill_sready", OUT_W'(S_Ready), OUT_W'(1'b0));
                mr_mode = 1;
            end
            if (abort_at > 0 && words_seen >= abort_at) begin
                S_Valid = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                chk("rst_mvalid", OUT_W'(M_Valid), OUT_W'(1'b0));
                chk("rst_mlast", OUT_W'(M_Last), OUT_W'(1'b0));
                chk("rst_busy", OUT_W'(Busy), OUT_W'(1'b0));
                chk("rst_sready", OUT_W'(S_Ready), OUT_W'(1'b0));
                exp_data_q.delete();
                exp_last_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (guard > 5000) begin
                timeout("drive_beats");
                break;
            end
        end
        for (int e = 0; e < extra; e++) begin
            S_Valid = 1'b1;
            S_Data  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        S_Valid = 1'b0;

        guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (done_cnt == d0) timeout("wait_done");
        chk("queue_drained", OUT_W'(exp_data_q.size()), OUT_W'(0));
        chk("word_count", OUT_W'(words_seen), OUT_W'(nw));
        chk("beats_accepted", OUT_W'(acc_cnt), OUT_W'(tot));
        if (nw > 0) chk("done_after_last", OUT_W'(done_cyc - last_word_cyc), OUT_W'(1));
        exp_data_q.delete();
        exp_last_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mvalid", OUT_W'(M_Valid), OUT_W'(1'b0));
        chk("reset_mdata", M_Data, '0);
        chk("reset_mlast", OUT_W'(M_Last), OUT_W'(1'b0));
        chk("reset_done", OUT_W'(Done), OUT_W'(1'b0));
        chk("reset_busy", OUT_W'(Busy), OUT_W'(1'b0));
        chk("reset_sready", OUT_W'(S_Ready), OUT_W'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_sready", OUT_W'(S_Ready), OUT_W'(1'b0));

        run_frame(2, 1, 0, 0, 0, 0, 0);    // two full words
        run_frame(3, 1, 0, 0, 0, 0, 0);    // odd total, zero-filled last word
        run_frame(8, 1, 0, 3, 0, 0, 40);   // stall fills FIFO, then toggling ready
        run_frame(8, 1, 0, 1, 0, 0, 0);    // toggling ready throughout
        run_frame(8, 1, 0, 2, 6, 0, 0);    // surplus beats must not be consumed
        run_frame(5, 3, 1, 2, 0, 0, 0);    // random valid and ready
        run_frame(8, 1, 0, 0, 0, 10, 0);   // reset mid-frame
        run_frame(8, 1, 1, 2, 0, 0, 0);    // clean frame after reset

        // Empty frame: Done three cycles after Start, repeat Start ignored.
        mr_mode    = 0;
        words_seen = 0;
        Row_Num_Out_REG     = 12'd4;
        Channel_Out_Num_REG = 10'd0;
        Start = 1'b1;
        @(posedge clk); #1;
        chk("zero_busy", OUT_W'(Busy), OUT_W'(1'b1));
        Channel_Out_Num_REG = 10'd1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("zero_no_done_early", OUT_W'(Done), OUT_W'(1'b0));
        @(posedge clk); #1;
        chk("zero_done", OUT_W'(Done), OUT_W'(1'b1));
        @(posedge clk); #1;
        chk("zero_done_fall", OUT_W'(Done), OUT_W'(1'b0));
        chk("zero_idle", OUT_W'(Busy), OUT_W'(1'b0));
        repeat (4) @(posedge clk);
        #1;
        chk("zero_no_words", OUT_W'(words_seen), OUT_W'(0));
        chk("zero_still_idle", OUT_W'(Busy), OUT_W'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
